// File: rtl/dma_ctrl.sv
// Single-channel byte-copy DMA engine: requests the bus from the CPU, then
// alternates read and write cycles from a source region to a destination region.
module dma_ctrl #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic              src_io,
  input  logic              dst_io,
  input  logic              abort,
  input  logic              dma_ack,
  input  logic              pad_wait,
  input  logic [7:0]        data_bus_in,
  output logic              dma_req,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              rd,
  output logic              wr,
  output logic              mem_io,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              src_io_q, src_io_d, dst_io_q, dst_io_d;
  logic              abort_seen_q, abort_seen_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              dma_req_q, dma_req_d, rd_q, rd_d, wr_q, wr_d;
  logic              mem_io_q, mem_io_d, busy_q, busy_d, done_q, done_d;
  logic              aborted_q, aborted_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    src_io_d     = src_io_q;
    dst_io_d     = dst_io_q;
    abort_seen_d = abort_seen_q;
    data_out_d   = data_out_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          cnt_d        = xfer_len;
          src_io_d     = src_io;
          dst_io_d     = dst_io;
          aborted_d    = 1'b0;
          abort_seen_d = 1'b0;
          if (xfer_len == '0) done_d  = 1'b1;
          else                state_d = REQ;
        end
      end
      REQ: begin
        if (dma_ack) state_d = RD;
      end
      RD: begin
        if (abort) abort_seen_d = 1'b1;
        if (!pad_wait) begin
          data_out_d = data_bus_in;
          state_d    = WR;
        end
      end
      WR: begin
        if (abort) abort_seen_d = 1'b1;
        if (!pad_wait) begin
          cnt_d = cnt_q - 1'b1;
          src_d = src_io_q ? src_q : src_q + 1'b1;
          dst_d = dst_io_q ? dst_q : dst_q + 1'b1;
          if (cnt_q == LEN_W'(1) || abort_seen_q || abort) begin
            state_d   = REL;
            aborted_d = abort_seen_q | abort;
          end else if (!dma_ack) begin
            state_d = REQ;
          end else begin
            state_d = RD;
          end
        end
      end
      REL: begin
        if (!dma_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered alongside the state, so they follow the next state.
    dma_req_d = (state_d == REQ) || (state_d == RD) || (state_d == WR);
    rd_d      = (state_d == RD);
    wr_d      = (state_d == WR);
    addr_d    = rd_d ? src_d : (wr_d ? dst_d : addr_q);
    mem_io_d  = rd_d ? !src_io_d : (wr_d ? !dst_io_d : mem_io_q);
    busy_d    = (state_d != IDLE) || done_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      src_io_q     <= 1'b0;
      dst_io_q     <= 1'b0;
      abort_seen_q <= 1'b0;
      data_out_q   <= '0;
      dma_req_q    <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      mem_io_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      src_io_q     <= src_io_d;
      dst_io_q     <= dst_io_d;
      abort_seen_q <= abort_seen_d;
      data_out_q   <= data_out_d;
      dma_req_q    <= dma_req_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      mem_io_q     <= mem_io_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign dma_req  = dma_req_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign mem_io   = mem_io_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: each command is run for a fixed window with a
// small bus-partner model, the per-cycle outputs are logged, then checked.
module tb_dma_ctrl;

  localparam int NCYC = 24;

  logic        clk = 1'b0;
  logic        arst, start, src_io, dst_io, abort, dma_ack, pad_wait;
  logic [21:0] src_addr, dst_addr;
  logic [15:0] xfer_len;
  logic [7:0]  data_bus_in;
  logic        dma_req, rd, wr, mem_io, busy, done, aborted;
  logic [21:0] addr;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rd, wr, req, busy, done, abt, mio;
    logic [21:0] addr;
    logic [7:0]  dout;
  } ent_t;

  ent_t lg [NCYC];
  int   n_done, first_done, n_busy, n_wr, n_rd, n_req, overlap;

  dma_ctrl dut (
    .clk(clk), .arst(arst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .src_io(src_io), .dst_io(dst_io), .abort(abort),
    .dma_ack(dma_ack), .pad_wait(pad_wait), .data_bus_in(data_bus_in),
    .dma_req(dma_req), .addr(addr), .data_out(data_out), .rd(rd), .wr(wr),
    .mem_io(mem_io), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one command starting at cycle 0; inputs are driven at each negedge.
  // Knobs of 0 / -1 disable the corresponding event.
  task automatic run(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n,
                     input logic sio, input logic dio, input int wait_rd, input int wait_n,
                     input int drop_wr, input int drop_n, input int abort_rd,
                     input int restart_k, input int rst_k);
    logic req_prev, rd_prev, wr_prev;
    int   rd_num, wr_num, waits, drop_left;
    req_prev = 1'b0; rd_prev = 1'b0; wr_prev = 1'b0;
    rd_num = 0; wr_num = 0; waits = 0; drop_left = 0;
    for (int k = 0; k < NCYC; k++) begin
      lg[k] = '{rd: rd, wr: wr, req: dma_req, busy: busy, done: done, abt: aborted,
                mio: mem_io, addr: addr, dout: data_out};
      if (rd && !rd_prev) rd_num++;
      if (wr && !wr_prev) begin
        wr_num++;
        if (wr_num == drop_wr) drop_left = drop_n;
      end
      start = (k == 0) || (k == restart_k);
      if (k == 0) begin
        src_addr = s; dst_addr = d; xfer_len = n; src_io = sio; dst_io = dio;
      end else if (k == restart_k) begin
        src_addr = 22'h300; dst_addr = 22'h380; xfer_len = 16'd1; src_io = 1'b1; dst_io = 1'b1;
      end
      arst        = (k == rst_k);
      pad_wait    = 1'b0;
      abort       = 1'b0;
      data_bus_in = 8'h00;
      if (rd) begin
        if (rd_num == wait_rd && waits < wait_n) begin
          pad_wait    = 1'b1;
          data_bus_in = 8'hEE;
          waits++;
        end else begin
          data_bus_in = addr[7:0] ^ 8'hA5;
        end
        if (rd_num == abort_rd) abort = 1'b1;
      end
      dma_ack = (drop_left > 0) ? 1'b0 : req_prev;
      if (drop_left > 0) drop_left--;
      req_prev = dma_req; rd_prev = rd; wr_prev = wr;
      @(negedge clk);
    end
    start = 1'b0; arst = 1'b0; pad_wait = 1'b0; abort = 1'b0; dma_ack = 1'b0;
  endtask

  task automatic summarize();
    n_done = 0; first_done = -1; n_busy = 0; n_wr = 0; n_rd = 0; n_req = 0; overlap = 0;
    for (int k = 0; k < NCYC; k++) begin
      if (lg[k].done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (lg[k].busy) n_busy++;
      if (lg[k].wr && (k == 0 || !lg[k-1].wr)) n_wr++;
      if (lg[k].rd) n_rd++;
      if (lg[k].req) n_req++;
      if (lg[k].rd && lg[k].wr) overlap++;
    end
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; src_io = 1'b0; dst_io = 1'b0; abort = 1'b0;
    dma_ack = 1'b0; pad_wait = 1'b0; src_addr = '0; dst_addr = '0; xfer_len = '0;
    data_bus_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {dma_req, rd, wr, busy, done, aborted, mem_io}, 7'b0000001);
    chk("rst_addr", {addr, data_out}, 30'h0);
    arst = 1'b0;
    @(negedge clk);

    // Basic copy: 4 bytes, 0x100 -> 0x200.
    run(22'h100, 22'h200, 16'd4, 1'b0, 1'b0, 0, 0, 0, 0, 0, -1, -1);
    summarize();
    chk("b_req_c1", {lg[1].req, lg[1].busy, lg[2].rd}, 3'b110);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_rd%0d", i), {lg[3+2*i].rd, lg[3+2*i].wr, lg[3+2*i].mio, lg[3+2*i].addr},
          {3'b101, 22'h100 + 22'(i)});
      chk($sformatf("b_wr%0d", i), {lg[4+2*i].rd, lg[4+2*i].wr, lg[4+2*i].mio, lg[4+2*i].addr,
          lg[4+2*i].dout}, {3'b011, 22'h200 + 22'(i), 8'(i) ^ 8'hA5});
    end
    chk("b_req_fall", {lg[10].req, lg[11].req}, 2'b10);
    chk("b_done", {n_done, first_done}, {32'd1, 32'd13});
    chk("b_busy", {n_busy, 31'd0, lg[0].busy}, {32'd13, 32'd0});
    chk("b_overlap", overlap, 0);

    // Wait states: 3 wait cycles on the second read.
    run(22'h100, 22'h200, 16'd4, 1'b0, 1'b0, 2, 3, 0, 0, 0, -1, -1);
    summarize();
    chk("w_rd_hold", {lg[4].rd, lg[5].rd, lg[6].rd, lg[7].rd, lg[8].rd, lg[9].rd}, 6'b011110);
    chk("w_rd_addr", lg[8].addr, 22'h101);
    chk("w_capture", {lg[9].wr, lg[9].addr, lg[9].dout}, {1'b1, 22'h201, 8'hA4});
    chk("w_done", {n_done, first_done}, {32'd1, 32'd16});

    // Source wraps at the top of memory; destination is a fixed I/O port.
    run(22'h3FFFFE, 22'h000010, 16'd3, 1'b0, 1'b1, 0, 0, 0, 0, 0, -1, -1);
    summarize();
    chk("x_rd0", {lg[3].rd, lg[3].mio, lg[3].addr}, {2'b11, 22'h3FFFFE});
    chk("x_rd1", {lg[5].rd, lg[5].mio, lg[5].addr}, {2'b11, 22'h3FFFFF});
    chk("x_rd2", {lg[7].rd, lg[7].mio, lg[7].addr}, {2'b11, 22'h000000});
    chk("x_wr0", {lg[4].wr, lg[4].mio, lg[4].addr, lg[4].dout}, {2'b10, 22'h10, 8'h5B});
    chk("x_wr1", {lg[6].wr, lg[6].mio, lg[6].addr, lg[6].dout}, {2'b10, 22'h10, 8'h5A});
    chk("x_wr2", {lg[8].wr, lg[8].mio, lg[8].addr, lg[8].dout}, {2'b10, 22'h10, 8'hA5});
    chk("x_done", {n_done, first_done}, {32'd1, 32'd11});

    // Grant lost for 2 cycles during the write of byte 2 of 5.
    run(22'h100, 22'h200, 16'd5, 1'b0, 1'b0, 0, 0, 2, 2, 0, -1, -1);
    summarize();
    chk("g_wr2", {lg[6].wr, lg[6].req, lg[6].addr}, {2'b11, 22'h201});
    chk("g_req_hold", {lg[7].req, lg[7].rd, lg[7].wr, lg[8].req, lg[8].rd}, 5'b10010);
    chk("g_resume", {lg[9].rd, lg[9].addr}, {1'b1, 22'h102});
    chk("g_last", {lg[14].wr, lg[14].addr, lg[14].dout}, {1'b1, 22'h204, 8'hA1});
    chk("g_done", {n_done, first_done, n_wr}, {32'd1, 32'd17, 32'd5});

    // Abort during the read of byte 1 of 8.
    run(22'h100, 22'h200, 16'd8, 1'b0, 1'b0, 0, 0, 0, 0, 1, -1, -1);
    summarize();
    chk("a_byte1", {lg[4].wr, lg[4].dout, lg[5].req, lg[5].rd}, {1'b1, 8'hA5, 2'b00});
    chk("a_done", {n_done, first_done, n_wr}, {32'd1, 32'd7, 32'd1});
    chk("a_sticky", {lg[7].abt, lg[NCYC-1].abt}, 2'b11);

    // Zero-length command right after: done at cycle 1, no request.
    run(22'h100, 22'h200, 16'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, -1, -1);
    summarize();
    chk("z_done", {lg[1].done, lg[1].busy, lg[1].abt, lg[2].busy}, 4'b1100);
    chk("z_noreq", {n_done, n_req, n_rd}, {32'd1, 32'd0, 32'd0});

    // A start strobe mid-command is ignored.
    run(22'h100, 22'h200, 16'd2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 3, -1);
    summarize();
    chk("i_rd1", {lg[5].rd, lg[5].mio, lg[5].addr}, {2'b11, 22'h101});
    chk("i_wr1", {lg[6].wr, lg[6].mio, lg[6].addr}, {2'b11, 22'h201});
    chk("i_done", {n_done, first_done, n_wr}, {32'd1, 32'd9, 32'd2});

    // Reset asserted during the write of byte 1.
    run(22'h100, 22'h200, 16'd4, 1'b0, 1'b0, 0, 0, 0, 0, 0, -1, 4);
    summarize();
    chk("r_pre", {lg[4].wr, lg[4].busy, lg[4].dout}, {2'b11, 8'hA5});
    chk("r_post", lg[5], {7'b0000001, 22'h0, 8'h0});
    chk("r_idle", {n_done, 31'd0, lg[NCYC-1].req, 31'd0, lg[NCYC-1].busy}, 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
